// File: rtl/output_gain_stage.sv
// ---------------------------------------------------------------------------
// output_gain_stage
//   Post-filter output gain stage that sits between the highpass filter and
//   the codec transmit interface. Each accepted sample is multiplied by a
//   smoothed gain, scaled down by 2**FRAC, saturated to W bits, and driven
//   out with a one-cycle out_valid strobe. The gain word ramps toward
//   gain_target by at most STEP per accepted sample, which avoids zipper
//   noise. A sticky clip flag records saturation.
//
//   Optional build macro: OUTGAIN_PEAK_EN
//     defined   - peak-hold meter with HOLD-sample hold and 1/16 decay
//     undefined - peak is tied to zero; no hold counter or meter logic
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for sample_en; latches operands and steps cur_gain
//   MULT  | registers the full-width signed product
//   SAT   | scales, saturates, drives gainOut/out_valid, updates meter
// ---------------------------------------------------------------------------
module output_gain_stage #(
    parameter int W    = 16,
    parameter int GW   = 8,
    parameter int FRAC = 6,
    parameter int STEP = 1,
    parameter int HOLD = 4800
) (
    input  logic                 clk_144,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic signed [W-1:0]  gainIn,
    input  logic [GW-1:0]        gain_target,
    input  logic                 clip_clr,
    output logic signed [W-1:0]  gainOut,
    output logic                 out_valid,
    output logic                 clip,
    output logic [W-2:0]         peak,
    output logic [GW-1:0]        cur_gain
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam int PW = W + GW + 1;

    localparam logic [GW-1:0]        STEP_G  = GW'(STEP);
    localparam logic signed [PW-1:0] SAT_MAX = {{(GW + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(GW + 2){1'b1}}, {(W - 1){1'b0}}};
    localparam logic signed [W-1:0]  OUT_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic signed [W-1:0]  OUT_MIN = {1'b1, {(W - 1){1'b0}}};

    state_t                state;
    logic signed [W-1:0]   sample_op;
    logic [GW-1:0]         gain_op;
    logic signed [PW-1:0]  product;

    logic [GW-1:0]         gain_diff;
    logic [GW-1:0]         gain_delta;
    logic [GW-1:0]         gain_next;

    logic signed [PW-1:0]  sample_ext;
    logic signed [PW-1:0]  gain_ext;
    logic signed [PW-1:0]  mult_full;
    logic signed [PW-1:0]  scaled;
    logic signed [W-1:0]   sat_val;
    logic                  sat_hit;

    // Next ramp value: move toward the target by at most STEP, never overshoot
    always_comb begin
        gain_diff  = '0;
        gain_delta = '0;
        gain_next  = cur_gain;
        if (gain_target > cur_gain) begin
            gain_diff  = gain_target - cur_gain;
            gain_delta = (gain_diff < STEP_G) ? gain_diff : STEP_G;
            gain_next  = cur_gain + gain_delta;
        end else if (gain_target < cur_gain) begin
            gain_diff  = cur_gain - gain_target;
            gain_delta = (gain_diff < STEP_G) ? gain_diff : STEP_G;
            gain_next  = cur_gain - gain_delta;
        end
    end

    // Signed sample times zero-extended (always positive) gain, full precision
    always_comb begin
        sample_ext = {{(GW + 1){sample_op[W-1]}}, sample_op};
        gain_ext   = {{(W + 1){1'b0}}, gain_op};
        mult_full  = sample_ext * gain_ext;
    end

    // Floor scaling by the arithmetic shift, then clamp to the W-bit range
    always_comb begin
        scaled  = product >>> FRAC;
        sat_hit = 1'b0;
        sat_val = scaled[W-1:0];
        if (scaled > SAT_MAX) begin
            sat_hit = 1'b1;
            sat_val = OUT_MAX;
        end else if (scaled < SAT_MIN) begin
            sat_hit = 1'b1;
            sat_val = OUT_MIN;
        end
    end

    // Main sequencing FSM with registered datapath and outputs
    always_ff @(posedge clk_144) begin
        if (reset) begin
            state     <= IDLE;
            sample_op <= '0;
            gain_op   <= '0;
            product   <= '0;
            cur_gain  <= '0;
            gainOut   <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // A saturation in SAT below overrides this clear in the same cycle
            if (clip_clr) begin
                clip <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sample_en) begin
                        sample_op <= gainIn;
                        gain_op   <= cur_gain;
                        cur_gain  <= gain_next;
                        state     <= MULT;
                    end
                end
                MULT: begin
                    product <= mult_full;
                    state   <= SAT;
                end
                SAT: begin
                    gainOut   <= sat_val;
                    out_valid <= 1'b1;
                    if (sat_hit) begin
                        clip <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef OUTGAIN_PEAK_EN
    localparam int              HW        = $clog2(HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
    localparam logic [W-2:0]    MAG_ONE   = {{(W - 2){1'b0}}, 1'b1};

    logic [HW-1:0] hold_cnt;
    logic [W-2:0]  sat_mag;

    // Magnitude of the value being output; the most negative code reads as full scale
    always_comb begin
        if (!sat_val[W-1]) begin
            sat_mag = sat_val[W-2:0];
        end else if (sat_val == OUT_MIN) begin
            sat_mag = '1;
        end else begin
            sat_mag = (~sat_val[W-2:0]) + MAG_ONE;
        end
    end

    // Peak meter: capture new highs, hold for HOLD samples, then decay by 1/16 per sample
    always_ff @(posedge clk_144) begin
        if (reset) begin
            peak     <= '0;
            hold_cnt <= '0;
        end else if (state == SAT) begin
            if (sat_mag >= peak) begin
                peak     <= sat_mag;
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_ONE;
            end else begin
                peak <= peak - (peak >> 4);
            end
        end
    end
`else
    // Meter disabled: report silence
    assign peak = '0;
`endif

endmodule

// File: tb/tb_output_gain_stage.sv
// ---------------------------------------------------------------------------
// tb_output_gain_stage
//   Self-checking bench for output_gain_stage. A behavioural model (integer
//   arithmetic on the gain ramp, floor scaling, clamp, clip and peak meter)
//   predicts every accepted sample; a table of settled-gain vectors and a few
//   hand-written sequences cover saturation, clip races, busy strobes and
//   reset during operation. Peak expectations follow OUTGAIN_PEAK_EN.
// ---------------------------------------------------------------------------
module tb_output_gain_stage;

    logic               clk_144 = 1'b0;
    logic               reset = 1'b1;
    logic               sample_en = 1'b0;
    logic signed [15:0] gainIn = '0;
    logic [7:0]         gain_target = '0;
    logic               clip_clr = 1'b0;
    logic signed [15:0] gainOut;
    logic               out_valid;
    logic               clip;
    logic [14:0]        peak;
    logic [7:0]         cur_gain;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int cur_m  = 0;
    int peak_m = 0;
    int hold_m = 0;
    bit clip_m = 1'b0;

    typedef struct {
        int tgt;
        int x;
        int exp_out;
        bit exp_clip;
    } vec_t;

    vec_t vecs[7];

    output_gain_stage dut (
        .clk_144     (clk_144),
        .reset       (reset),
        .sample_en   (sample_en),
        .gainIn      (gainIn),
        .gain_target (gain_target),
        .clip_clr    (clip_clr),
        .gainOut     (gainOut),
        .out_valid   (out_valid),
        .clip        (clip),
        .peak        (peak),
        .cur_gain    (cur_gain)
    );

    always #5 clk_144 = ~clk_144;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int step_toward(input int cur, input int tgt);
        if (tgt > cur) return cur + 1;
        if (tgt < cur) return cur - 1;
        return cur;
    endfunction

    function automatic int floor_div64(input int p);
        int q;
        q = p / 64;
        if ((p % 64 != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int exp_peak();
`ifdef OUTGAIN_PEAK_EN
        return peak_m;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        cur_m  = 0;
        peak_m = 0;
        hold_m = 0;
        clip_m = 1'b0;
    endtask

    // Drive one sample from a negedge, optionally keep sample_en high while busy,
    // optionally pulse clip_clr into the output cycle; checks latency and result.
    task automatic send(input int x, input bit clr, input bit busy, output int got);
        int g;
        int o;
        int mag;
        bit sat;
        g     = cur_m;
        cur_m = step_toward(cur_m, int'(gain_target));
        o     = floor_div64(x * g);
        sat   = 1'b0;
        if (o > 32767) begin o = 32767; sat = 1'b1; end
        if (o < -32768) begin o = -32768; sat = 1'b1; end
        if (sat) clip_m = 1'b1;
        else if (clr) clip_m = 1'b0;
        mag = (o < 0) ? -o : o;
        if (mag > 32767) mag = 32767;
        if (mag >= peak_m) begin
            peak_m = mag;
            hold_m = 4800;
        end else if (hold_m > 0) begin
            hold_m = hold_m - 1;
        end else begin
            peak_m = peak_m - peak_m / 16;
        end

        sample_en = 1'b1;
        gainIn    = 16'(x);
        @(negedge clk_144);
        sample_en = busy;
        chk("lat_cycle1", int'(out_valid), 0);
        @(negedge clk_144);
        sample_en = 1'b0;
        clip_clr  = clr;
        chk("lat_cycle2", int'(out_valid), 0);
        @(negedge clk_144);
        clip_clr = 1'b0;
        chk("out_valid", int'(out_valid), 1);
        chk("gainOut", int'(gainOut), o);
        chk("clip", int'(clip), int'(clip_m));
        chk("cur_gain", int'(cur_gain), cur_m);
        chk("peak", int'(peak), exp_peak());
        got = int'(gainOut);
    endtask

    task automatic settle(input int tgt);
        int got;
        gain_target = 8'(tgt);
        for (int i = 0; i < 300 && cur_m != tgt; i++) send(0, 1'b0, 1'b0, got);
        chk("settle_gain", int'(cur_gain), tgt);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(negedge clk_144);
        @(negedge clk_144);
        reset = 1'b0;
        model_reset();
        @(negedge clk_144);
    endtask

    initial begin
        int got;
        int x;
        bit clr;

        vecs[0] = '{tgt: 128, x:  20000, exp_out:  32767, exp_clip: 1'b1};
        vecs[1] = '{tgt: 128, x: -20000, exp_out: -32768, exp_clip: 1'b1};
        vecs[2] = '{tgt: 128, x:    100, exp_out:    200, exp_clip: 1'b1};
        vecs[3] = '{tgt:  32, x:     -3, exp_out:     -2, exp_clip: 1'b1};
        vecs[4] = '{tgt:  32, x:     64, exp_out:     32, exp_clip: 1'b1};
        vecs[5] = '{tgt:  96, x: -12345, exp_out: -18518, exp_clip: 1'b1};
        vecs[6] = '{tgt:  64, x:     -1, exp_out:     -1, exp_clip: 1'b1};

        // reset state
        reset_dut();
        chk("rst_gainOut", int'(gainOut), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_peak", int'(peak), 0);
        chk("rst_cur_gain", int'(cur_gain), 0);

        // fade-in ramp from silence
        gain_target = 8'd64;
        for (int k = 0; k < 70; k++) begin
            send(1000, 1'b0, 1'b0, got);
            if (k == 1)  chk("ramp_k1", got, 15);
            if (k == 32) chk("ramp_k32", got, 500);
            if (k == 64 || k == 69) begin
                chk("ramp_settled_out", got, 1000);
                chk("ramp_settled_gain", int'(cur_gain), 64);
            end
        end

        // settled-gain vector table (clip cleared first)
        clip_clr = 1'b1;
        @(negedge clk_144);
        clip_clr = 1'b0;
        clip_m   = 1'b0;
        chk("clip_cleared", int'(clip), 0);
        for (int i = 0; i < 7; i++) begin
            settle(vecs[i].tgt);
            send(vecs[i].x, 1'b0, 1'b0, got);
            chk("vec_out", got, vecs[i].exp_out);
            chk("vec_clip", int'(clip), int'(vecs[i].exp_clip));
        end

        // clip_clr in the same cycle as a saturating output: set wins
        settle(128);
        send(20000, 1'b1, 1'b0, got);
        chk("race_clip_set_wins", int'(clip), 1);
        @(negedge clk_144);
        clip_clr = 1'b1;
        @(negedge clk_144);
        clip_clr = 1'b0;
        clip_m   = 1'b0;
        chk("clip_clr_alone", int'(clip), 0);

        // sample_en held into the busy cycle: one output, one gain step
        gain_target = 8'((cur_m < 200) ? cur_m + 10 : cur_m - 10);
        send(777, 1'b0, 1'b1, got);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_144);
            chk("busy_no_extra_valid", int'(out_valid), 0);
        end
        chk("busy_single_step", int'(cur_gain), cur_m);

        // reset while in MULT drops the sample
        sample_en = 1'b1;
        gainIn    = 16'sd5000;
        @(negedge clk_144);
        sample_en = 1'b0;
        reset     = 1'b1;
        @(negedge clk_144);
        reset = 1'b0;
        model_reset();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_gainOut", int'(gainOut), 0);
        chk("midrst_cur_gain", int'(cur_gain), 0);
        chk("midrst_clip", int'(clip), 0);
        chk("midrst_peak", int'(peak), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_144);
            chk("midrst_dropped", int'(out_valid), 0);
        end

        // randomized samples and targets against the model
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) gain_target = 8'($urandom_range(0, 255));
            x   = int'($urandom_range(0, 65535)) - 32768;
            clr = ($urandom_range(0, 7) == 0);
            send(x, clr, 1'b0, got);
        end

        // peak hold and decay
        reset_dut();
        settle(64);
        send(-32768, 1'b0, 1'b0, got);
        chk("peak_capture_out", got, -32768);
`ifdef OUTGAIN_PEAK_EN
        chk("peak_capture", int'(peak), 32767);
`else
        chk("peak_capture", int'(peak), 0);
`endif
        for (int i = 0; i < 4800; i++) send(0, 1'b0, 1'b0, got);
`ifdef OUTGAIN_PEAK_EN
        chk("peak_held", int'(peak), 32767);
`else
        chk("peak_held", int'(peak), 0);
`endif
        send(0, 1'b0, 1'b0, got);
`ifdef OUTGAIN_PEAK_EN
        chk("peak_decay", int'(peak), 30720);
`else
        chk("peak_decay", int'(peak), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
